// File: rtl/counter_pkg.sv
// Shared types and widened step arithmetic
// for the modulo up/down counter.
package counter_pkg;

  typedef enum logic [0:0] {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  localparam int CNT_XW = 33;

  typedef logic [CNT_XW-1:0] cnt_x_t;

  typedef struct packed {
    cnt_x_t val;
    logic   limit;
  } cnt_step_t;

  // One bit wider than any count so MODULUS=2**WIDTH stays exact.
  function automatic cnt_step_t cnt_step(
    input cnt_x_t    cur,
    input logic      up,
    input cnt_x_t    modulus,
    input cnt_mode_t mode
  );
    cnt_step_t r;
    cnt_x_t    one;
    cnt_x_t    top;
    one     = cnt_x_t'(1);
    top     = modulus - one;
    r.limit = up ? (cur == top) : (cur == '0);
    r.val   = up ? (cur + one) : (cur - one);
    if (r.limit) begin
      if (mode == CNT_SAT) begin
        r.val = cur;
      end else begin
        r.val = up ? '0 : top;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable-gated prescaler producing one tick
// every PRESCALE enabled cycles.
module cnt_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_ps
    $fatal(1, "cnt_prescaler: PRESCALE out of range");
  end

  if (PRESCALE == 1) begin : g_direct
    logic unused_in;
    assign unused_in = clk ^ rst_n ^ sync_clr;
    assign tick      = en;
  end else begin : g_div
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_q;
    logic [PW-1:0] ps_d;

    assign tick = en && (ps_q == LAST);

    always_comb begin
      ps_d = ps_q;
      if (sync_clr || tick) begin
        ps_d = '0;
      end else if (en) begin
        ps_d = ps_q + PW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ps_q <= '0;
      end else begin
        ps_q <= ps_d;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Prescaled modulo up/down counter with wrap or
// saturate limits, terminal-count pulse and sticky ovf.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter int        MODULUS  = 2**WIDTH,
  parameter int        PRESCALE = 1,
  parameter cnt_mode_t MODE     = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 30) begin : g_bad_w
    $fatal(1, "mod_updown_counter: WIDTH out of range");
  end

  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_mod
    $fatal(1, "mod_updown_counter: MODULUS out of range");
  end

  if (PRESCALE < 1) begin : g_bad_ps
    $fatal(1, "mod_updown_counter: PRESCALE must be >= 1");
  end

  localparam cnt_x_t MOD_X = cnt_x_t'(MODULUS);
  localparam cnt_x_t TOP_X = MOD_X - cnt_x_t'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             tick;
  cnt_x_t           cnt_x;
  cnt_x_t           ld_x;
  logic [WIDTH-1:0] ld_val;
  cnt_step_t        step;
  logic             unused_hi;

  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_ps (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  assign cnt_x     = cnt_x_t'(cnt_q);
  assign ld_x      = cnt_x_t'(load_val);
  assign step      = cnt_step(cnt_x, up, MOD_X, MODE);
  assign unused_hi = ^step.val[CNT_XW-1:WIDTH];

  assign ld_val = (ld_x >= MOD_X) ? TOP_X[WIDTH-1:0]
                                  : load_val;

  // A load on a tick edge suppresses that tick entirely.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = ld_val;
    end else if (tick) begin
      cnt_d = step.val[WIDTH-1:0];
      if (step.limit) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Four counter configurations on a shared stimulus bus,
// scoreboarded against a behavioural model.
module tb_mod_updown_counter;
  import counter_pkg::*;

  localparam int N = 4;
  localparam int MODS [N] = '{10, 10, 10, 16};
  localparam int PSS  [N] = '{1, 1, 3, 1};
  localparam bit SATS [N] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cnt_w [N];
  logic [N-1:0] tc_w;
  logic [N-1:0] ovf_w;

  always #5 clk = ~clk;

  mod_updown_counter #(
    .WIDTH(4), .MODULUS(10), .PRESCALE(1), .MODE(CNT_WRAP)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(load_val),
    .cnt(cnt_w[0]), .tc(tc_w[0]), .ovf(ovf_w[0])
  );

  mod_updown_counter #(
    .WIDTH(4), .MODULUS(10), .PRESCALE(1), .MODE(CNT_SAT)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(load_val),
    .cnt(cnt_w[1]), .tc(tc_w[1]), .ovf(ovf_w[1])
  );

  mod_updown_counter #(
    .WIDTH(4), .MODULUS(10), .PRESCALE(3), .MODE(CNT_WRAP)
  ) u_ps3 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(load_val),
    .cnt(cnt_w[2]), .tc(tc_w[2]), .ovf(ovf_w[2])
  );

  mod_updown_counter #(
    .WIDTH(4), .MODULUS(16), .PRESCALE(1), .MODE(CNT_WRAP)
  ) u_m16 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(load_val),
    .cnt(cnt_w[3]), .tc(tc_w[3]), .ovf(ovf_w[3])
  );

  typedef struct {
    int idx;
    int cnt;
    bit tc;
    bit ovf;
  } exp_t;

  exp_t sb [$];

  int m_cnt [N];
  int m_ps  [N];
  bit m_tc  [N];
  bit m_ovf [N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_ps[i]  = 0;
      m_tc[i]  = 1'b0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i);
    bit tick;
    m_tc[i] = 1'b0;
    if (clr) begin
      m_cnt[i] = 0;
      m_ps[i]  = 0;
      m_ovf[i] = 1'b0;
    end else if (load) begin
      m_cnt[i] = (int'(load_val) >= MODS[i]) ? MODS[i] - 1
                                             : int'(load_val);
      m_ps[i]  = 0;
    end else begin
      tick = en && (m_ps[i] == PSS[i] - 1);
      if (tick) begin
        m_ps[i] = 0;
        if (up && m_cnt[i] == MODS[i] - 1) begin
          m_tc[i] = 1'b1;
          m_ovf[i] = 1'b1;
          if (!SATS[i]) m_cnt[i] = 0;
        end else if (!up && m_cnt[i] == 0) begin
          m_tc[i] = 1'b1;
          m_ovf[i] = 1'b1;
          if (!SATS[i]) m_cnt[i] = MODS[i] - 1;
        end else begin
          m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
        end
      end else if (en) begin
        m_ps[i] = m_ps[i] + 1;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      model_edge(i);
      e.idx = i;
      e.cnt = m_cnt[i];
      e.tc  = m_tc[i];
      e.ovf = m_ovf[i];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("sb_cnt%0d", e.idx), cnt_w[e.idx], e.cnt);
      check($sformatf("sb_tc%0d", e.idx), tc_w[e.idx], e.tc);
      check($sformatf("sb_ovf%0d", e.idx), ovf_w[e.idx], e.ovf);
    end
  endtask

  task automatic idle();
    en = 0; up = 1; clr = 0; load = 0; load_val = 0;
  endtask

  int tcs;

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #2;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_cnt%0d", i), cnt_w[i], 0);
      check($sformatf("rst_tc%0d", i), tc_w[i], 0);
      check($sformatf("rst_ovf%0d", i), ovf_w[i], 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // wrap up-count through the modulus
    clr = 1; cycle(); clr = 0;
    en = 1; up = 1; tcs = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check("A_cnt", cnt_w[0], k % 10);
      check("A_tc", tc_w[0], (k == 10) ? 1 : 0);
      tcs += int'(tc_w[0]);
    end
    check("A_tcs", tcs, 1);
    check("A_ovf", ovf_w[0], 1);

    // saturating down-count at zero
    idle(); clr = 1; cycle(); clr = 0;
    load = 1; load_val = 1; cycle(); load = 0;
    check("B_ovf0", ovf_w[1], 0);
    en = 1; up = 0; tcs = 0;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("B_cnt", cnt_w[1], 0);
      check("B_tc", tc_w[1], (k >= 2) ? 1 : 0);
      tcs += int'(tc_w[1]);
    end
    check("B_tcs", tcs, 2);
    check("B_ovf", ovf_w[1], 1);

    // prescale by 3 with enable gaps
    idle(); clr = 1; cycle(); clr = 0;
    en = 1; up = 1;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      check("C_cnt", cnt_w[2], k / 3);
    end
    en = 0; cycle(); cycle();
    check("C_gap1", cnt_w[2], 3);
    en = 1; cycle(); cycle();
    check("C_part", cnt_w[2], 3);
    en = 0; cycle(); cycle();
    check("C_gap2", cnt_w[2], 3);
    en = 1; cycle();
    check("C_resume", cnt_w[2], 4);

    // load clamp, load+clr, load on a limit tick
    idle(); load = 1; load_val = 12; cycle();
    check("D_clamp", cnt_w[0], 9);
    load = 0; en = 1; up = 1; cycle();
    check("D_ovf_pre", ovf_w[0], 1);
    en = 0; load = 1; clr = 1; load_val = 5; cycle();
    check("D_lc_cnt", cnt_w[0], 0);
    check("D_lc_ovf", ovf_w[0], 0);
    clr = 0; load_val = 9; cycle();
    en = 1; cycle();
    check("D_lt_cnt", cnt_w[0], 9);
    check("D_lt_tc", tc_w[0], 0);
    check("D_lt_ovf", ovf_w[0], 0);

    // async reset mid prescale interval
    idle(); load = 1; load_val = 9; cycle();
    load = 0; en = 1; cycle();
    load = 1; load_val = 7; en = 0; cycle();
    load = 0; en = 1; cycle();
    check("E_pre_cnt", cnt_w[2], 7);
    check("E_pre_ovf", ovf_w[0], 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("E_cnt%0d", i), cnt_w[i], 0);
      check($sformatf("E_tc%0d", i), tc_w[i], 0);
      check($sformatf("E_ovf%0d", i), ovf_w[i], 0);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("E_step", cnt_w[2], (k == 3) ? 1 : 0);
    end

    // full power-of-two modulus, both directions
    idle(); clr = 1; cycle(); clr = 0;
    load = 1; load_val = 15; cycle(); load = 0;
    en = 1; up = 1; cycle();
    check("F_up_cnt", cnt_w[3], 0);
    check("F_up_tc", tc_w[3], 1);
    up = 0; cycle();
    check("F_dn_cnt", cnt_w[3], 15);
    check("F_dn_tc", tc_w[3], 1);
    idle(); cycle();
    check("F_tc_low", tc_w[3], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
